// File: rtl/collision_detect.sv
// Dino/obstacle hitbox scan; COLLISION_MARGIN_EN shrinks obstacle boxes by MARGIN per side.
// Latency: tick at t -> isColision/hit_slot registered in DONE, visible at t+5.
// Backpressure: none; tick while busy is dropped, not queued.
module collision_detect #(
    parameter int DINO_X           = 40,
    parameter int GROUND_Y         = 400,
    parameter int LOW_BIRD_BOTTOM  = 370,
    parameter int HIGH_BIRD_BOTTOM = 330,
    parameter int MARGIN           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] game_state,
    input  logic [9:0] dino_pos,
    input  logic       dino_behavior,
    input  logic [9:0] danger_pos1,
    input  logic [9:0] danger_pos2,
    input  logic [9:0] danger_pos3,
    input  logic [2:0] danger_type1,
    input  logic [2:0] danger_type2,
    input  logic [2:0] danger_type3,
    input  logic       danger_en1,
    input  logic       danger_en2,
    input  logic       danger_en3,
    output logic       isColision,
    output logic [1:0] hit_slot,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN1 = 3'd1;
    localparam logic [2:0] S_SCAN2 = 3'd2;
    localparam logic [2:0] S_SCAN3 = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_START = 2'd1;
    localparam logic [1:0] GS_RESET = 2'd3;

`ifdef COLLISION_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif
    localparam logic [10:0] SHRINK = MARGIN_ON ? 11'(MARGIN) : 11'd0;

    localparam logic [10:0] DX0 = 11'(DINO_X);
    localparam logic [10:0] GND = 11'(GROUND_Y);
    localparam logic [10:0] LBB = 11'(LOW_BIRD_BOTTOM);
    localparam logic [10:0] HBB = 11'(HIGH_BIRD_BOTTOM);

    logic [2:0] state;
    logic [1:0] snap_state;
    logic [9:0] snap_dino_pos;
    logic       snap_beh;
    logic [9:0] snap_pos1, snap_pos2, snap_pos3;
    logic [2:0] snap_type1, snap_type2, snap_type3;
    logic       snap_en1, snap_en2, snap_en3;
    logic       hit_acc;
    logic [1:0] acc_slot;

    logic [9:0]  cur_pos;
    logic [2:0]  cur_type;
    logic        cur_en;
    logic        ob_ok;
    logic [10:0] ob_w, ob_h, ob_bot;
    logic [10:0] ob_x0, ob_x1, ob_y0, ob_y1;
    logic [10:0] d_w, d_h, d_x1, d_y0, d_y1;
    logic        slot_hit;

    assign busy = (state != S_IDLE);

    always_comb begin
        cur_pos  = '0;
        cur_type = 3'd5;
        cur_en   = 1'b0;
        case (state)
            S_SCAN1: begin cur_pos = snap_pos1; cur_type = snap_type1; cur_en = snap_en1; end
            S_SCAN2: begin cur_pos = snap_pos2; cur_type = snap_type2; cur_en = snap_en2; end
            S_SCAN3: begin cur_pos = snap_pos3; cur_type = snap_type3; cur_en = snap_en3; end
            default: ;
        endcase
    end

    always_comb begin
        ob_ok  = 1'b1;
        ob_w   = '0;
        ob_h   = '0;
        ob_bot = GND;
        case (cur_type)
            3'd0:    begin ob_w = 11'd47; ob_h = 11'd42; ob_bot = LBB; end
            3'd1:    begin ob_w = 11'd47; ob_h = 11'd42; ob_bot = HBB; end
            3'd2:    begin ob_w = 11'd19; ob_h = 11'd36; end
            3'd3:    begin ob_w = 11'd77; ob_h = 11'd49; end
            3'd4:    begin ob_w = 11'd27; ob_h = 11'd50; end
            default: ob_ok = 1'b0;
        endcase
    end

    // Tops clamp at 0 so a box reaching above the screen never wraps to a huge y.
    always_comb begin
        ob_x0 = {1'b0, cur_pos} + SHRINK;
        ob_x1 = {1'b0, cur_pos} + ob_w - SHRINK;
        ob_y0 = ((ob_bot > ob_h) ? (ob_bot - ob_h) : 11'd0) + SHRINK;
        ob_y1 = ob_bot - SHRINK;
        d_w   = snap_beh ? 11'd44 : 11'd59;
        d_h   = snap_beh ? 11'd47 : 11'd30;
        d_x1  = DX0 + d_w;
        d_y1  = {1'b0, snap_dino_pos};
        d_y0  = (d_y1 > d_h) ? (d_y1 - d_h) : 11'd0;
    end

    assign slot_hit = ob_ok && cur_en &&
                      (DX0 < ob_x1) && (ob_x0 < d_x1) &&
                      (d_y0 < ob_y1) && (ob_y0 < d_y1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            isColision    <= 1'b0;
            hit_slot      <= 2'd0;
            snap_state    <= '0;
            snap_dino_pos <= '0;
            snap_beh      <= 1'b0;
            snap_pos1     <= '0;
            snap_pos2     <= '0;
            snap_pos3     <= '0;
            snap_type1    <= '0;
            snap_type2    <= '0;
            snap_type3    <= '0;
            snap_en1      <= 1'b0;
            snap_en2      <= 1'b0;
            snap_en3      <= 1'b0;
            hit_acc       <= 1'b0;
            acc_slot      <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state         <= S_SCAN1;
                        snap_state    <= game_state;
                        snap_dino_pos <= dino_pos;
                        snap_beh      <= dino_behavior;
                        snap_pos1     <= danger_pos1;
                        snap_pos2     <= danger_pos2;
                        snap_pos3     <= danger_pos3;
                        snap_type1    <= danger_type1;
                        snap_type2    <= danger_type2;
                        snap_type3    <= danger_type3;
                        snap_en1      <= danger_en1;
                        snap_en2      <= danger_en2;
                        snap_en3      <= danger_en3;
                        hit_acc       <= 1'b0;
                        acc_slot      <= 2'd0;
                    end
                end
                S_SCAN1, S_SCAN2, S_SCAN3: begin
                    // SCANn encodes as n, so the state doubles as the slot number.
                    if (slot_hit && !hit_acc) begin
                        hit_acc  <= 1'b1;
                        acc_slot <= state[1:0];
                    end
                    state <= state + 3'd1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (snap_state == GS_START && hit_acc) begin
                        isColision <= 1'b1;
                        hit_slot   <= acc_slot;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (game_state == GS_RESET || game_state == GS_INIT) begin
                isColision <= 1'b0;
                hit_slot   <= 2'd0;
            end
        end
    end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 Parameter DINO_X, 40: fixed screen x of dino left edge.
REQ-002 Parameter GROUND_Y, 400: screen y of ground line; bottom edge of all cacti.
REQ-003 Parameter LOW_BIRD_BOTTOM, 370: bottom y of LOW_BIRD (type 0).
REQ-004 Parameter HIGH_BIRD_BOTTOM, 330: bottom y of HIGH_BIRD (type 1).
REQ-005 Parameter MARGIN, 4: hitbox shrink per side when COLLISION_MARGIN_EN is defined.
REQ-006 clk  in  1  system clock; one clock only.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle pulse (clk domain) starting a scan.
REQ-009 game_state  in  2  0 INIT, 1 START, 2 END, 3 RESET.
REQ-010 dino_pos  in  10  dino bottom-edge y (GROUND_Y when grounded).
REQ-011 dino_behavior  in  1  0 sit, 1 stand.
REQ-012 danger_pos1/2/3  in  10 each  obstacle left-edge x.
REQ-013 danger_type1/2/3  in  3 each  0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5 NOTHING.
REQ-014 danger_en1/2/3  in  1 each  slot valid.
REQ-015 isColision  out  1  sticky collision flag.
REQ-016 hit_slot  out  2  first colliding slot (1..3), 0 = none.
REQ-017 busy  out  1  high while scan in progress.

Function
REQ-018 FSM states IDLE, SCAN1, SCAN2, SCAN3, DONE; tick in IDLE -> SCAN1, then one state per clk, DONE -> IDLE.
REQ-019 On tick accepted in IDLE: snapshot all data inputs; scan uses snapshot only.
REQ-020 tick while busy: ignored, no queueing.
REQ-021 busy = 1 in SCAN1..DONE, 0 in IDLE.
REQ-022 Sizes (W x H): stand 44x47, sit 59x30, SMALL 19x36, MANY 77x49, BIG 27x50, birds 47x42.
REQ-023 Dino box: x [DINO_X, DINO_X+W), y [dino_pos-H, dino_pos); H and W from snapshotted dino_behavior.
REQ-024 Obstacle box: x [pos, pos+W), y [bottom-H, bottom); bottom = GROUND_Y for cacti, bird bottoms per REQ-003/004.
REQ-025 Slot hits iff en=1, type != NOTHING (and type <= 4), and boxes overlap on both axes (strict inequalities, half-open intervals).
REQ-026 All box arithmetic in 11-bit unsigned; negative intermediate tops clamp to 0; no wrap-around.
REQ-027 Hit accumulates across SCAN states; hit_slot records lowest-numbered hitting slot.
REQ-028 In DONE: if snapshot game_state == START and any hit, isColision <= 1 and hit_slot <= recorded slot; otherwise both unchanged.
REQ-029 Scan result latency: tick at cycle t -> isColision valid at t+5 (registered in DONE).
REQ-030 isColision holds once set; cleared to 0 (hit_slot to 0) in any cycle where live game_state is RESET or INIT, overriding a simultaneous DONE set.
REQ-031 Snapshot game_state != START: scan runs, never sets isColision.

Reset
REQ-032 rst high at clk edge: FSM -> IDLE, isColision 0, hit_slot 0, busy 0, snapshot registers 0; aborts scan mid-operation with no output update.
REQ-033 tick coincident with rst: ignored.

Configuration
REQ-034 Macro COLLISION_MARGIN_EN: defined -> every obstacle box shrunk by MARGIN on all four sides (width/height reduced by 2*MARGIN) before overlap test; undefined -> exact boxes per REQ-022.

Verification
REQ-035 START, stand, dino_pos 400, slot1 BIG_CACTUS pos 50, en1=1, tick -> busy 4 cycles, isColision 1, hit_slot 1 at t+5.
REQ-036 START, dino_pos 340 (top 293), slot2 SMALL_CACTUS pos 50 -> no hit (cactus top 364 >= dino bottom 340), isColision stays 0.
REQ-037 START, sit, dino_pos 400, slot1 HIGH_BIRD pos 50 -> no hit; same with stand -> no hit (bird 288..330 vs dino 353..400); LOW_BIRD pos 50 stand -> hit, sit -> no hit (328..370 vs 370..400).
REQ-038 Slots 2 and 3 both overlapping -> hit_slot 2; second tick during busy ignored; then game_state RESET -> isColision 0, hit_slot 0 next cycle.
REQ-039 Scan started, rst asserted in SCAN2 -> all outputs 0, FSM IDLE; slot at pos 84 (edge touch, DINO_X+44) -> no hit; with COLLISION_MARGIN_EN, slot at pos 80 -> no hit, pos 78 -> hit.
